engine_job_scheduler: RTL and testbench

Shares one AXI-Lite engine adaptor (the `engine_start`/`payload`/`engine_done`/`return_code` front end of a kernel) between NUM_REQ job requesters in the job manager. It arbitrates round-robin, launches one job at a time by loading a 1024-bit payload and pulsing start, and waits for done. It then returns the engine's return code to the granted requester, or flags a timeout if the engine never finishes.

---
 rtl/engine_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/engine_job_scheduler.sv | 121 ++++++++++++
 tb/tb_engine_job_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_sched_pkg.sv
// Shared definitions for the engine job scheduler: FSM states and datapath widths.
package engine_sched_pkg;

   localparam int PAYLOAD_W = 1024;
   localparam int RC_WORD_W = 32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
   parameter int  NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               found
);

   always_comb begin : arb
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         // ptr < NUM_REQ, so one conditional subtract is enough to wrap
         sum = {1'b0, ptr} + (IDX_W+1)'(off);
         if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
         idx = sum[IDX_W-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/engine_job_scheduler.sv
// Shares one engine adaptor between NUM_REQ requesters: round-robin accept, launch,
// wait for done (or timeout), and return the code to the owning requester.
module engine_job_scheduler
   import engine_sched_pkg::*;
#(
   parameter int  NUM_REQ        = 4,
   parameter int  RC_WORDS       = 1,
   parameter int  TIMEOUT_CYCLES = 'd1000000,
   parameter int  CNT_WIDTH      = 32,
   localparam int IDX_W          = $clog2(NUM_REQ),
   localparam int RC_W           = RC_WORDS * RC_WORD_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [RC_W-1:0]                rsp_code,
   output logic                           rsp_timeout,
   output logic                           eng_start,
   output logic [PAYLOAD_W-1:0]           eng_payload,
   input  logic                           eng_done,
   input  logic [RC_W-1:0]                eng_return_code,
   output logic                           busy,
   output logic [IDX_W-1:0]               grant_id
);

   // Handshake: a requester holds req_valid until it sees its one-cycle req_ready
   // pulse; rsp_valid is a one-cycle pulse with no back-pressure from the requester.

   localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NUM_REQ - 1);

   sched_state_t         state, state_next;
   logic [IDX_W-1:0]     rr_ptr;
   logic [CNT_WIDTH-1:0] counter;
   logic [NUM_REQ-1:0]   arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_found;
   logic                 accept, done_hit, to_hit;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .found     (arb_found)
   );

   // Arbitration also runs in RESP so a waiting requester is accepted right after
   // the response; the IDLE cycle carrying req_ready then moves straight to LAUNCH.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done_hit   = 1'b0;
      to_hit     = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_ready != '0) state_next = S_LAUNCH;
            else                 accept     = arb_found;
         end
         S_LAUNCH: state_next = S_WAIT;
         S_WAIT: begin
            if (eng_done) begin
               done_hit   = 1'b1;
               state_next = S_RESP;
            end else if (TO_EN && counter == TO_LAST) begin
               to_hit     = 1'b1;
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            state_next = S_IDLE;
            accept     = arb_found;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         req_ready   <= '0;
         rsp_valid   <= '0;
         eng_start   <= 1'b0;
         eng_payload <= '0;
         rsp_code    <= '0;
         rsp_timeout <= 1'b0;
         counter     <= '0;
      end else begin
         state     <= state_next;
         req_ready <= '0;
         rsp_valid <= '0;
         eng_start <= (state == S_IDLE) && (state_next == S_LAUNCH);
         if (accept) begin
            req_ready   <= arb_grant;
            eng_payload <= req_payload[arb_idx*PAYLOAD_W +: PAYLOAD_W];
            grant_id    <= arb_idx;
            rr_ptr      <= (arb_idx == IDX_MAX) ? '0 : arb_idx + 1'b1;
         end
         if (state == S_LAUNCH)    counter <= '0;
         else if (state == S_WAIT) counter <= counter + 1'b1;
         if (done_hit) begin
            rsp_code    <= eng_return_code;
            rsp_timeout <= 1'b0;
            rsp_valid   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
         end else if (to_hit) begin
            rsp_code    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_engine_job_scheduler.sv
// Bench for engine_job_scheduler: a job table applied in a loop against a small
// engine model, plus hand-written reset and mid-job abort sequences.
module tb_engine_job_scheduler;
   import engine_sched_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int RC_W    = 32;

   typedef struct {
      bit           sel;          // 0: no-timeout instance, 1: TIMEOUT_CYCLES=16 instance
      bit           rst_first;
      logic [3:0]   valid;
      bit           keep;         // requester keeps req_valid after accept
      bit           clear_after;  // drop all requests once the response is seen
      int           delay;        // engine done this many cycles after start, 0 = never
      logic [31:0]  code;
      int           exp_grant;
      logic [31:0]  exp_code;
      bit           exp_to;
      int           exp_lat;      // rsp_valid cycle minus eng_start cycle
      int           exp_gap;      // accept-to-accept distance, 0 = not checked
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NUM_REQ-1:0]           req_valid = '0;
   logic [NUM_REQ*PAYLOAD_W-1:0] req_payload;
   logic                         eng_done = 1'b0;
   logic [RC_W-1:0]              eng_return_code = '0;
   logic [7:0]                   pbyte [NUM_REQ] = '{8'h11, 8'h22, 8'hA5, 8'h44};

   logic [NUM_REQ-1:0] req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
   logic [RC_W-1:0]    rsp_code_a, rsp_code_b;
   logic               rsp_timeout_a, rsp_timeout_b, eng_start_a, eng_start_b, busy_a, busy_b;
   logic [PAYLOAD_W-1:0] eng_payload_a, eng_payload_b;
   logic [IDX_W-1:0]   grant_id_a, grant_id_b;

   engine_job_scheduler #(.NUM_REQ(NUM_REQ), .RC_WORDS(1), .TIMEOUT_CYCLES(0), .CNT_WIDTH(32)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_payload(req_payload),
      .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_code(rsp_code_a),
      .rsp_timeout(rsp_timeout_a), .eng_start(eng_start_a), .eng_payload(eng_payload_a),
      .eng_done(eng_done), .eng_return_code(eng_return_code), .busy(busy_a), .grant_id(grant_id_a)
   );

   engine_job_scheduler #(.NUM_REQ(NUM_REQ), .RC_WORDS(1), .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_payload(req_payload),
      .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_code(rsp_code_b),
      .rsp_timeout(rsp_timeout_b), .eng_start(eng_start_b), .eng_payload(eng_payload_b),
      .eng_done(eng_done), .eng_return_code(eng_return_code), .busy(busy_b), .grant_id(grant_id_b)
   );

   // observed instance
   bit sel = 1'b0;
   logic [NUM_REQ-1:0]   o_req_ready, o_rsp_valid;
   logic [RC_W-1:0]      o_rsp_code;
   logic                 o_rsp_timeout, o_eng_start, o_busy;
   logic [PAYLOAD_W-1:0] o_eng_payload;
   logic [IDX_W-1:0]     o_grant_id;
   always_comb begin
      o_req_ready   = sel ? req_ready_b   : req_ready_a;
      o_rsp_valid   = sel ? rsp_valid_b   : rsp_valid_a;
      o_rsp_code    = sel ? rsp_code_b    : rsp_code_a;
      o_rsp_timeout = sel ? rsp_timeout_b : rsp_timeout_a;
      o_eng_start   = sel ? eng_start_b   : eng_start_a;
      o_eng_payload = sel ? eng_payload_b : eng_payload_a;
      o_busy        = sel ? busy_b        : busy_a;
      o_grant_id    = sel ? grant_id_b    : grant_id_a;
   end

   // engine model: level done raised eng_delay cycles after start, held until next start
   int          eng_delay = 0;
   logic [31:0] eng_code  = '0;
   int          eng_cnt   = 0;
   bit          eng_armed = 1'b0;
   always @(negedge clk) begin
      if (o_eng_start) begin
         eng_done  = 1'b0;
         eng_cnt   = 0;
         eng_armed = 1'b1;
      end else if (eng_armed) begin
         eng_cnt++;
         if (eng_delay != 0 && eng_cnt == eng_delay) begin
            eng_done        = 1'b1;
            eng_return_code = eng_code;
            eng_armed       = 1'b0;
         end
      end
   end

   // scoreboard
   int errors = 0;
   int checks = 0;
   int last_acc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input bit s);
      sel       = s;
      rst       = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [PAYLOAD_W-1:0] exp_payload(input int g);
      logic [7:0] b;
      b = pbyte[g];
      return {128{b}};
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, " req_ready"},   64'(o_req_ready), 0);
      check({tag, " rsp_valid"},   64'(o_rsp_valid), 0);
      check({tag, " rsp_code"},    64'(o_rsp_code), 0);
      check({tag, " rsp_timeout"}, 64'(o_rsp_timeout), 0);
      check({tag, " eng_start"},   64'(o_eng_start), 0);
      check({tag, " eng_payload"}, 64'(o_eng_payload == '0), 1);
      check({tag, " busy"},        64'(o_busy), 0);
      check({tag, " grant_id"},    64'(o_grant_id), 0);
   endtask

   task automatic wait_accept(input string tag, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         if (o_req_ready != '0) seen = 1'b1;
      end
      check({tag, " accept_seen"}, 64'(seen), 1);
   endtask

   task automatic run_vec(input int i, input vec_t v);
      string tag;
      bit    seen;
      int    t_acc, n, starts;
      tag = $sformatf("v%0d", i);
      if (v.rst_first) do_reset(v.sel);
      eng_delay = v.delay;
      eng_code  = v.code;
      req_valid = v.valid;
      wait_accept(tag, seen);
      if (!seen) return;
      t_acc = cyc;
      check({tag, " req_ready"},   64'(o_req_ready), 64'(1 << v.exp_grant));
      check({tag, " grant_id"},    64'(o_grant_id), 64'(v.exp_grant));
      check({tag, " eng_payload"}, 64'(o_eng_payload == exp_payload(v.exp_grant)), 1);
      if (v.exp_gap != 0) check({tag, " accept_gap"}, 64'(t_acc - last_acc), 64'(v.exp_gap));
      last_acc = t_acc;
      if (!v.keep) req_valid = req_valid & ~o_req_ready;
      @(negedge clk);
      check({tag, " eng_start_on"}, 64'(o_eng_start), 1);
      @(negedge clk);
      check({tag, " eng_start_off"}, 64'(o_eng_start), 0);
      check({tag, " busy"}, 64'(o_busy), 1);
      seen   = 1'b0;
      starts = 0;
      n      = 0;
      while (!seen && n < 100) begin
         if (o_rsp_valid != '0) seen = 1'b1;
         else begin
            if (o_eng_start) starts++;
            @(negedge clk);
            n++;
         end
      end
      check({tag, " rsp_seen"}, 64'(seen), 1);
      if (!seen) return;
      check({tag, " extra_start"}, 64'(starts), 0);
      check({tag, " rsp_latency"}, 64'(cyc - t_acc - 1), 64'(v.exp_lat));
      check({tag, " rsp_valid"},   64'(o_rsp_valid), 64'(1 << v.exp_grant));
      check({tag, " rsp_code"},    64'(o_rsp_code), 64'(v.exp_code));
      check({tag, " rsp_timeout"}, 64'(o_rsp_timeout), 64'(v.exp_to));
      if (v.clear_after) req_valid = '0;
   endtask

   function automatic vec_t mk(input bit s, input bit r, input logic [3:0] va, input bit k,
                               input bit c, input int d, input logic [31:0] cd, input int g,
                               input logic [31:0] ec, input bit et, input int lat, input int gap);
      vec_t v;
      v.sel = s; v.rst_first = r; v.valid = va; v.keep = k; v.clear_after = c;
      v.delay = d; v.code = cd; v.exp_grant = g; v.exp_code = ec; v.exp_to = et;
      v.exp_lat = lat; v.exp_gap = gap;
      return v;
   endfunction

   vec_t vecs [14];

   initial begin
      bit seen;
      int n_rsp;
      vec_t v_after;
      for (int i = 0; i < NUM_REQ; i++) req_payload[i*PAYLOAD_W +: PAYLOAD_W] = exp_payload(i);

      // round robin with all requesters held valid, engine done after 5 cycles
      vecs[0]  = mk(0, 1, 4'b1111, 1, 0,  5, 32'h100, 0, 32'h100, 0,  6, 0);
      vecs[1]  = mk(0, 0, 4'b1111, 1, 0,  5, 32'h101, 1, 32'h101, 0,  6, 8);
      vecs[2]  = mk(0, 0, 4'b1111, 1, 0,  5, 32'h102, 2, 32'h102, 0,  6, 8);
      vecs[3]  = mk(0, 0, 4'b1111, 1, 0,  5, 32'h103, 3, 32'h103, 0,  6, 8);
      vecs[4]  = mk(0, 0, 4'b1111, 1, 1,  5, 32'h104, 0, 32'h104, 0,  6, 8);
      // single job from requester 2, then stale-done job from requester 0
      vecs[5]  = mk(0, 0, 4'b0100, 0, 0, 20, 32'h1,   2, 32'h1,   0, 21, 0);
      vecs[6]  = mk(0, 0, 4'b0001, 0, 0,  7, 32'h77,  0, 32'h77,  0,  8, 0);
      // minimum turnaround and pointer wrap
      vecs[7]  = mk(0, 0, 4'b1010, 0, 0,  1, 32'h1A,  1, 32'h1A,  0,  2, 0);
      vecs[8]  = mk(0, 0, 4'b1010, 0, 0,  1, 32'h1B,  3, 32'h1B,  0,  2, 4);
      vecs[9]  = mk(0, 0, 4'b0011, 0, 1,  3, 32'h09,  0, 32'h09,  0,  4, 4);
      // TIMEOUT_CYCLES=16 instance: timeout, normal job, coincidence, one-before
      vecs[10] = mk(1, 1, 4'b0001, 0, 0,  0, 32'hDEAD, 0, 32'h0,  1, 17, 0);
      vecs[11] = mk(1, 0, 4'b0010, 0, 0,  3, 32'h33,  1, 32'h33,  0,  4, 19);
      vecs[12] = mk(1, 0, 4'b0100, 0, 0, 16, 32'h55,  2, 32'h55,  0, 17, 0);
      vecs[13] = mk(1, 0, 4'b1000, 0, 1, 15, 32'h66,  3, 32'h66,  0, 16, 0);

      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("reset");
      sel = 1'b1;
      check_idle_outputs("reset_b");
      sel = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // reset asserted for one cycle while the engine job is in WAIT
      eng_delay = 0;
      req_valid = 4'b0010;
      wait_accept("abort", seen);
      check("abort grant_id", 64'(o_grant_id), 1);
      req_valid = '0;
      repeat (4) @(negedge clk);
      check("abort busy_before", 64'(o_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("abort");
      n_rsp = 0;
      repeat (25) begin
         @(negedge clk);
         if (o_rsp_valid != '0) n_rsp++;
      end
      check("abort no_rsp", 64'(n_rsp), 0);
      v_after = mk(0, 0, 4'b1111, 0, 1, 2, 32'h99, 0, 32'h99, 0, 3, 0);
      run_vec(100, v_after);

      for (int i = 10; i < 14; i++) run_vec(i, vecs[i]);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
